dense_1_engine: RTL and testbench

Sequential multiply-accumulate engine for the first fully connected layer of the quantized CNN. It sits directly downstream of the dense-1 weight memory and the flattened feature buffer. It drives both memories' read addresses, accumulates zero-point-corrected products per output neuron, requantizes each sum to 8 bits, and hands neurons one at a time to the next stage over a valid/ready handshake.

---
 rtl/dense_1_engine.sv | 209 ++++++++++++++++++++
 tb/tb_dense_1_engine.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dense_1_engine.sv
// -----------------------------------------------------------------------------
// dense_1_engine
//
// Sequential multiply-accumulate engine for the first fully connected layer of
// the quantized CNN. It reads each weight/activation pair in turn from the
// dense-1 weight memory and the flattened feature buffer. For each output
// neuron it accumulates the zero-point-corrected products, requantizes the sum
// to 8 bits, and then offers the result downstream over a valid/ready
// handshake.
//
// Ports
//   clk        : clock, all logic on the rising edge
//   rst_n      : synchronous active-low reset
//   start      : one-cycle request to process a full layer (ignored unless idle)
//   busy       : layer in progress
//   done       : one-cycle pulse after the last neuron is accepted
//   w_en       : weight memory read enable
//   w_addr     : weight memory read address (n*NUM_IN + k, counted, not multiplied)
//   w_rdata    : signed weight, valid one cycle after w_en
//   act_en     : activation buffer read enable
//   act_addr   : activation index k
//   act_rdata  : unsigned activation, valid one cycle after act_en
//   out_valid  : out_data/out_idx valid
//   out_ready  : downstream accepts when high together with out_valid
//   out_idx    : neuron index n
//   out_data   : requantized unsigned neuron value
// -----------------------------------------------------------------------------
module dense_1_engine #(
    parameter int          NUM_IN            = 169,
    parameter int          NUM_OUT           = 3,
    parameter int          addressWidthDense = 10,
    parameter int          ACT_AW            = 8,
    parameter int          dataWidthDense    = 8,
    parameter int          ACC_W             = 32,
    parameter logic [31:0] Q_MULT            = 32'd2014687024,
    parameter int          Q_SHIFT           = 31,
    parameter int          offset_ent        = 1,
    parameter int          offset_sor        = -1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         w_en,
    output logic [addressWidthDense-1:0] w_addr,
    input  logic [dataWidthDense-1:0]    w_rdata,
    output logic                         act_en,
    output logic [ACT_AW-1:0]            act_addr,
    input  logic [dataWidthDense-1:0]    act_rdata,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [1:0]                   out_idx,
    output logic [dataWidthDense-1:0]    out_data
);

    localparam int                 AXW      = dataWidthDense + 2;      // offset activation width
    localparam int                 PW       = AXW + dataWidthDense;    // product width
    localparam logic [ACT_AW-1:0]  K_LAST   = ACT_AW'(NUM_IN - 1);
    localparam logic [1:0]         N_LAST   = 2'(NUM_OUT - 1);
    localparam logic signed [63:0] RND_HALF = 64'sd1 <<< (Q_SHIFT - 1);
    localparam logic signed [63:0] OUT_MAX  = 64'sd255;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        QUANT = 3'd3,
        SAT   = 3'd4,
        OUT   = 3'd5
    } state_t;

    state_t                   state_r;
    logic [ACT_AW-1:0]        k_r;
    logic [1:0]               n_r;
    logic                     vld_r;
    logic signed [ACC_W-1:0]  acc_r;
    logic signed [63:0]       prod_r;

    logic signed [AXW-1:0]    act_ext_s;
    logic signed [PW-1:0]     mac_s;
    logic signed [ACC_W-1:0]  mac_ext_s;
    logic signed [63:0]       acc64_s;
    logic signed [63:0]       mul_s;
    logic signed [63:0]       rnd_s;
    logic signed [63:0]       v_s;
    logic [dataWidthDense-1:0] sat_s;

    // Clamp a signed requantized value into the unsigned output range.
    function automatic logic [dataWidthDense-1:0] sat_u(input logic signed [63:0] v);
        logic [dataWidthDense-1:0] r;
        if (v < 64'sd0) begin
            r = {dataWidthDense{1'b0}};
        end else if (v > OUT_MAX) begin
            r = {dataWidthDense{1'b1}};
        end else begin
            r = v[dataWidthDense-1:0];
        end
        return r;
    endfunction

    // Datapath: offset activation, MAC product, requant multiply, round/shift, clamp.
    always_comb begin
        // Activation is unsigned; two guard bits keep 255 + zero-point positive.
        act_ext_s = $signed({2'b00, act_rdata}) + $signed(AXW'(offset_ent));
        mac_s     = $signed({{dataWidthDense{act_ext_s[AXW-1]}}, act_ext_s})
                  * $signed({{AXW{w_rdata[dataWidthDense-1]}}, w_rdata});
        mac_ext_s = $signed({{(ACC_W-PW){mac_s[PW-1]}}, mac_s});
        acc64_s   = $signed({{(64-ACC_W){acc_r[ACC_W-1]}}, acc_r});
        // Multiplier is unsigned 32-bit, so zero-extend before the signed multiply.
        mul_s     = acc64_s * $signed({32'd0, Q_MULT});
        rnd_s     = (prod_r + RND_HALF) >>> Q_SHIFT;
        v_s       = rnd_s + 64'(offset_sor);
        sat_s     = sat_u(v_s);
    end

    // Control FSM, address counters, accumulator and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            k_r       <= {ACT_AW{1'b0}};
            n_r       <= 2'd0;
            vld_r     <= 1'b0;
            acc_r     <= {ACC_W{1'b0}};
            prod_r    <= 64'sd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            w_en      <= 1'b0;
            w_addr    <= {addressWidthDense{1'b0}};
            act_en    <= 1'b0;
            act_addr  <= {ACT_AW{1'b0}};
            out_valid <= 1'b0;
            out_idx   <= 2'd0;
            out_data  <= {dataWidthDense{1'b0}};
        end else begin
            done  <= 1'b0;
            // Read data arrives one cycle after the enable; this flag tracks it.
            vld_r <= w_en;
            if (vld_r) begin
                acc_r <= acc_r + mac_ext_s;
            end

            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r  <= RUN;
                        busy     <= 1'b1;
                        acc_r    <= {ACC_W{1'b0}};
                        k_r      <= {ACT_AW{1'b0}};
                        n_r      <= 2'd0;
                        w_addr   <= {addressWidthDense{1'b0}};
                        act_addr <= {ACT_AW{1'b0}};
                        w_en     <= 1'b1;
                        act_en   <= 1'b1;
                    end
                end
                RUN: begin
                    // k_r is the index currently on the address bus.
                    if (k_r == K_LAST) begin
                        w_en    <= 1'b0;
                        act_en  <= 1'b0;
                        state_r <= DRAIN;
                    end else begin
                        k_r      <= k_r + ACT_AW'(1);
                        act_addr <= k_r + ACT_AW'(1);
                        w_addr   <= w_addr + addressWidthDense'(1);
                    end
                end
                DRAIN: begin
                    state_r <= QUANT;
                end
                QUANT: begin
                    prod_r  <= mul_s;
                    state_r <= SAT;
                end
                SAT: begin
                    out_data  <= sat_s;
                    out_idx   <= n_r;
                    out_valid <= 1'b1;
                    state_r   <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (n_r == N_LAST) begin
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            state_r <= IDLE;
                        end else begin
                            // Weight counter simply continues into the next row.
                            n_r      <= n_r + 2'd1;
                            acc_r    <= {ACC_W{1'b0}};
                            k_r      <= {ACT_AW{1'b0}};
                            act_addr <= {ACT_AW{1'b0}};
                            w_addr   <= w_addr + addressWidthDense'(1);
                            w_en     <= 1'b1;
                            act_en   <= 1'b1;
                            state_r  <= RUN;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dense_1_engine.sv
// -----------------------------------------------------------------------------
// tb_dense_1_engine
//
// Self-checking bench for dense_1_engine. Behavioural one-cycle-latency models
// of the weight memory and activation buffer respond to the engine's reads.
// Expected neuron results go into a scoreboard queue when a layer is started.
// They come from a table of uniform-fill vectors or from a reference model.
// A negedge monitor checks the results on each handshake, together with the
// address sequence, output stability while stalled, and the restart timing.
// -----------------------------------------------------------------------------
module tb_dense_1_engine;

    localparam int NUM_IN  = 169;
    localparam int NUM_OUT = 3;
    localparam int WDEPTH  = NUM_IN * NUM_OUT;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       busy;
    logic       done;
    logic       w_en;
    logic [9:0] w_addr;
    logic [7:0] w_rdata;
    logic       act_en;
    logic [7:0] act_addr;
    logic [7:0] act_rdata;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_idx;
    logic [7:0] out_data;

    always #5 clk = ~clk;

    dense_1_engine dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .w_en      (w_en),
        .w_addr    (w_addr),
        .w_rdata   (w_rdata),
        .act_en    (act_en),
        .act_addr  (act_addr),
        .act_rdata (act_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_data  (out_data)
    );

    logic signed [7:0] wmem [0:WDEPTH-1];
    logic        [7:0] amem [0:NUM_IN-1];

    // Memories with one cycle of read latency.
    always @(posedge clk) begin
        if (w_en)   w_rdata   <= wmem[w_addr];
        if (act_en) act_rdata <= amem[act_addr];
    end

    typedef struct {
        logic [1:0] idx;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [7:0]        act;
        logic signed [7:0] w;
        logic [7:0]        exp;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl[4];

    int checks = 0;
    int errors = 0;
    int exp_addr = 0;
    int out_cnt = 0;

    bit         stall_prev = 1'b0;
    bit         acc_pend = 1'b0;
    logic [7:0] prev_data;
    logic [1:0] prev_idx;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference result for neuron n from the current memory contents.
    function automatic logic [7:0] model(input int n);
        longint acc = 0;
        longint p;
        longint r;
        longint v;
        for (int k = 0; k < NUM_IN; k++) begin
            acc += (longint'(amem[k]) + 1) * longint'(wmem[n*NUM_IN + k]);
        end
        p = acc * longint'(2014687024);
        r = (p + (longint'(1) << 30)) >>> 31;
        v = r - 1;
        if (v < 0)   return 8'd0;
        if (v > 255) return 8'd255;
        return 8'(v);
    endfunction

    task automatic fill_uniform(input logic [7:0] a, input logic signed [7:0] w);
        for (int i = 0; i < NUM_IN; i++) amem[i] = a;
        for (int i = 0; i < WDEPTH; i++) wmem[i] = w;
    endtask

    task automatic fill_random();
        for (int i = 0; i < NUM_IN; i++) amem[i] = 8'($urandom_range(0, 3));
        for (int i = 0; i < WDEPTH; i++) wmem[i] = 8'(int'($urandom_range(0, 3)) - 1);
    endtask

    task automatic push_model();
        exp_t e;
        for (int n = 0; n < NUM_OUT; n++) begin
            e.idx  = 2'(n);
            e.data = model(n);
            sb_q.push_back(e);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},      64'(busy),      64'd0);
        check({tag, "_done"},      64'(done),      64'd0);
        check({tag, "_w_en"},      64'(w_en),      64'd0);
        check({tag, "_w_addr"},    64'(w_addr),    64'd0);
        check({tag, "_act_en"},    64'(act_en),    64'd0);
        check({tag, "_act_addr"},  64'(act_addr),  64'd0);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_out_idx"},   64'(out_idx),   64'd0);
        check({tag, "_out_data"},  64'(out_data),  64'd0);
    endtask

    // Monitor: scoreboard pops, address sequence, stall stability, restart timing.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
            acc_pend   = 1'b0;
        end else begin
            if (acc_pend) begin
                check("next_run_start", 64'(w_en), 64'd1);
                acc_pend = 1'b0;
            end
            if (stall_prev) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data",  64'(out_data),  64'(prev_data));
                check("hold_idx",   64'(out_idx),   64'(prev_idx));
            end
            if (out_valid) begin
                check("no_read_while_valid", 64'(w_en), 64'd0);
            end
            if (w_en) begin
                check("w_addr_seq", 64'(w_addr),   64'(exp_addr));
                check("act_addr",   64'(act_addr), 64'(exp_addr % NUM_IN));
                check("act_en",     64'(act_en),   64'd1);
                exp_addr++;
            end
            if (out_valid && out_ready) begin
                out_cnt++;
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got idx %0d data %0d, expected no output", out_idx, out_data);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("out_idx",  64'(out_idx),  64'(e.idx));
                    check("out_data", 64'(out_data), 64'(e.data));
                end
                if (out_idx != 2'(NUM_OUT - 1)) acc_pend = 1'b1;
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            prev_idx   = out_idx;
        end
    end

    // One full layer. stall_n: neuron held off for 10 cycles (-1 none);
    // poke_start: pulse start during neuron 1's RUN; exp_lat: start-to-done cycles.
    task automatic run_layer(input int stall_n, input bit poke_start, input int exp_lat);
        int cyc = 0;
        int first_v = -1;
        int stall_cnt = 0;
        bit got_done = 1'b0;
        exp_addr = 0;
        out_cnt  = 0;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            cyc++;
            #1;
            if (first_v < 0 && out_valid) first_v = cyc;
            start = (poke_start && cyc == NUM_IN + 4 + 50);
            if (out_valid && int'(out_idx) == stall_n && stall_cnt < 10) begin
                out_ready = 1'b0;
                stall_cnt++;
            end else begin
                out_ready = 1'b1;
            end
            if (done) begin
                got_done = 1'b1;
                break;
            end
        end
        start = 1'b0;
        check("done_seen",    64'(got_done), 64'd1);
        check("done_latency", 64'(cyc),      64'(exp_lat));
        check("first_valid",  64'(first_v),  64'(NUM_IN + 3));
        check("busy_at_done", 64'(busy),     64'd0);
        @(posedge clk);
        #1;
        check("done_pulse", 64'(done), 64'd0);
        repeat (5) @(posedge clk);
        #1;
        check("idle_no_valid", 64'(out_valid), 64'd0);
        check("out_count",     64'(out_cnt),   64'(NUM_OUT));
        check("sb_empty",      64'(sb_q.size()), 64'd0);
        check("w_addr_total",  64'(exp_addr),  64'(WDEPTH));
    endtask

    initial begin
        exp_t e;
        bit   reached;
        rst_n     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        tbl[0] = '{act: 8'd0,   w: 8'sd0,   exp: 8'd0};
        tbl[1] = '{act: 8'd0,   w: 8'sd1,   exp: 8'd158};
        tbl[2] = '{act: 8'd255, w: 8'sd127, exp: 8'd255};
        tbl[3] = '{act: 8'd255, w: 8'h80,   exp: 8'd0};

        for (int i = 0; i < 4; i++) begin
            fill_uniform(tbl[i].act, tbl[i].w);
            for (int n = 0; n < NUM_OUT; n++) begin
                e.idx  = 2'(n);
                e.data = tbl[i].exp;
                sb_q.push_back(e);
            end
            run_layer(-1, 1'b0, 3 * (NUM_IN + 4));
        end

        // Stall neuron 1 for 10 cycles.
        fill_random();
        push_model();
        run_layer(1, 1'b0, 3 * (NUM_IN + 4) + 10);

        // start during neuron 1 must be ignored.
        fill_random();
        push_model();
        run_layer(-1, 1'b1, 3 * (NUM_IN + 4));

        // Reset in the middle of neuron 1, then a fresh layer.
        fill_random();
        push_model();
        exp_addr = 0;
        out_cnt  = 0;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        reached = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(posedge clk);
            #1;
            if (w_en && w_addr >= 10'(NUM_IN + 60)) begin
                reached = 1'b1;
                break;
            end
        end
        check("reached_neuron1", 64'(reached), 64'd1);
        check("neuron0_out", 64'(out_cnt), 64'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("midreset");
        rst_n = 1'b1;
        sb_q.delete();
        push_model();
        run_layer(-1, 1'b0, 3 * (NUM_IN + 4));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
